forward_hazard_unit: RTL and testbench

Parametrised forwarding and load-use hazard unit for the pipelined MIPS datapath. It keeps its own registered record of destination registers across the EX, MEM and WB stages. It produces registered per-operand forward selects for the instruction entering EX, and a combinational stall for the ID stage on load-use hazards. It sits beside the ID/EX pipeline register and replaces the combinational forward compare per operand. Saturating counters expose stall and forward activity for performance checks.

---
 rtl/forward_hazard_unit.sv | 167 ++++++++++++++++
 tb/tb_forward_hazard_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit
// Forwarding and load-use hazard unit for the pipelined MIPS datapath. It keeps
// its own record of the instructions in EX, MEM and WB. From that record it
// produces registered per-operand forward selects for the instruction entering
// EX, and a combinational stall for ID when an operand depends on a load.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   id_valid        ID holds a real instruction
//   id_src          source register numbers, operand i at [i*ADDR_W +: ADDR_W]
//   id_src_used     operand i is actually read
//   id_rd           destination register of the ID instruction
//   id_regwrite     ID instruction writes id_rd
//   id_memread      ID instruction is a load
//   flush           kill the ID instruction (taken branch)
//   id_stall        hold PC and IF/ID, insert a bubble into EX (combinational)
//   ex_fwd_sel      per-operand select for the EX instruction:
//                   00 regfile, 01 EX/MEM result, 10 MEM/WB result
//   stall_cnt       saturating count of cycles with id_stall=1
//   fwd_cnt         saturating count of cycles with any ex_fwd_sel nonzero
module forward_hazard_unit #(
    parameter int ADDR_W       = 5,
    parameter int NUM_SRC      = 2,
    parameter int LOAD_BUBBLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [NUM_SRC*ADDR_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [ADDR_W-1:0]         id_rd,
    input  logic                      id_regwrite,
    input  logic                      id_memread,
    input  logic                      flush,
    output logic                      id_stall,
    output logic [2*NUM_SRC-1:0]      ex_fwd_sel,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          fwd_cnt
);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic              regwrite;
        logic              memread;
    } entry_t;

    localparam logic [ADDR_W-1:0] ZERO_REG_C  = {ADDR_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX_C   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};
    // With two load bubbles the load result is never forwarded from MEM/WB,
    // so a load sitting in MEM is also a hazard.
    localparam logic              MEM_LOAD_HAZARD_C = (LOAD_BUBBLES == 2);

    entry_t                 ex_e_r;
    entry_t                 mem_e_r;
    entry_t                 wb_e_r;
    logic [2*NUM_SRC-1:0]   ex_fwd_sel_r;
    logic [CNT_W-1:0]       stall_cnt_r;
    logic [CNT_W-1:0]       fwd_cnt_r;

    logic                   load_use_s;
    logic                   id_stall_s;
    logic                   accept_s;
    logic [2*NUM_SRC-1:0]   sel_s;
    entry_t                 id_entry_s;

    // An entry produces a result worth forwarding only if it really writes a
    // nonzero register.
    function automatic logic is_writer(input entry_t e);
        return e.valid && e.regwrite && (e.rd != ZERO_REG_C);
    endfunction

    // Per-operand hazard compare and forward select, youngest producer first.
    always_comb begin
        load_use_s = 1'b0;
        sel_s      = {(2*NUM_SRC){1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            logic [ADDR_W-1:0] src_s;
            logic              reads_s;
            logic              ex_hit_s;
            logic              mem_hit_s;
            src_s     = id_src[i*ADDR_W +: ADDR_W];
            reads_s   = id_src_used[i] && (src_s != ZERO_REG_C);
            ex_hit_s  = is_writer(ex_e_r) && (ex_e_r.rd == src_s);
            mem_hit_s = is_writer(mem_e_r) && (mem_e_r.rd == src_s);

            if (id_valid && reads_s && ex_hit_s && ex_e_r.memread) begin
                load_use_s = 1'b1;
            end else if (id_valid && reads_s && MEM_LOAD_HAZARD_C &&
                         mem_hit_s && mem_e_r.memread) begin
                load_use_s = 1'b1;
            end else begin
                load_use_s = load_use_s;
            end

            // A load in EX never forwards; the stall above covers it.
            if (!reads_s) begin
                sel_s[2*i +: 2] = 2'b00;
            end else if (ex_hit_s && !ex_e_r.memread) begin
                sel_s[2*i +: 2] = 2'b01;
            end else if (mem_hit_s) begin
                sel_s[2*i +: 2] = (MEM_LOAD_HAZARD_C && mem_e_r.memread) ? 2'b00 : 2'b10;
            end else begin
                sel_s[2*i +: 2] = 2'b00;
            end
        end
    end

    // A flush kills the ID instruction, so there is nothing left to stall.
    assign id_stall_s = load_use_s && !flush;
    assign accept_s   = id_valid && !id_stall_s && !flush;

    assign id_entry_s.valid    = 1'b1;
    assign id_entry_s.rd       = id_rd;
    assign id_entry_s.regwrite = id_regwrite;
    assign id_entry_s.memread  = id_memread;

    // Pipeline record advance and registered forward selects.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_e_r       <= '0;
            mem_e_r      <= '0;
            wb_e_r       <= '0;
            ex_fwd_sel_r <= {(2*NUM_SRC){1'b0}};
        end else begin
            wb_e_r  <= mem_e_r;
            mem_e_r <= ex_e_r;
            if (accept_s) begin
                ex_e_r       <= id_entry_s;
                ex_fwd_sel_r <= sel_s;
            end else begin
                ex_e_r       <= '0;
                ex_fwd_sel_r <= {(2*NUM_SRC){1'b0}};
            end
        end
    end

    // Saturating count of stall cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (id_stall_s && (stall_cnt_r != CNT_MAX_C)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE_C;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Saturating count of cycles where the EX instruction uses a forward.
    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_cnt_r <= {CNT_W{1'b0}};
        end else if ((ex_fwd_sel_r != {(2*NUM_SRC){1'b0}}) && (fwd_cnt_r != CNT_MAX_C)) begin
            fwd_cnt_r <= fwd_cnt_r + CNT_ONE_C;
        end else begin
            fwd_cnt_r <= fwd_cnt_r;
        end
    end

    assign id_stall   = id_stall_s;
    assign ex_fwd_sel = ex_fwd_sel_r;
    assign stall_cnt  = stall_cnt_r;
    assign fwd_cnt    = fwd_cnt_r;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Bench for forward_hazard_unit. Three instances: defaults, two load bubbles,
// and 4-bit counters. Directed tables cover the named scenarios; a random
// phase compares each instance against an instruction-age reference model.
module tb_forward_hazard_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a  [3];
    logic       val_a  [3];
    logic [9:0] src_a  [3];
    logic [1:0] used_a [3];
    logic [4:0] rd_a   [3];
    logic       rw_a   [3];
    logic       mr_a   [3];
    logic       fl_a   [3];

    logic        stall0, stall1, stall2;
    logic [3:0]  sel0, sel1, sel2;
    logic [15:0] sc0, sc1, fc0, fc1;
    logic [3:0]  sc2, fc2;

    logic        stall_a [3];
    logic [3:0]  sel_a   [3];
    logic [15:0] sc_a    [3];
    logic [15:0] fc_a    [3];

    assign stall_a[0] = stall0;
    assign stall_a[1] = stall1;
    assign stall_a[2] = stall2;
    assign sel_a[0]   = sel0;
    assign sel_a[1]   = sel1;
    assign sel_a[2]   = sel2;
    assign sc_a[0]    = sc0;
    assign sc_a[1]    = sc1;
    assign sc_a[2]    = {12'd0, sc2};
    assign fc_a[0]    = fc0;
    assign fc_a[1]    = fc1;
    assign fc_a[2]    = {12'd0, fc2};

    forward_hazard_unit dut0 (
        .clk(clk), .reset(rst_a[0]), .id_valid(val_a[0]), .id_src(src_a[0]),
        .id_src_used(used_a[0]), .id_rd(rd_a[0]), .id_regwrite(rw_a[0]),
        .id_memread(mr_a[0]), .flush(fl_a[0]), .id_stall(stall0),
        .ex_fwd_sel(sel0), .stall_cnt(sc0), .fwd_cnt(fc0)
    );

    forward_hazard_unit #(.LOAD_BUBBLES(2)) dut1 (
        .clk(clk), .reset(rst_a[1]), .id_valid(val_a[1]), .id_src(src_a[1]),
        .id_src_used(used_a[1]), .id_rd(rd_a[1]), .id_regwrite(rw_a[1]),
        .id_memread(mr_a[1]), .flush(fl_a[1]), .id_stall(stall1),
        .ex_fwd_sel(sel1), .stall_cnt(sc1), .fwd_cnt(fc1)
    );

    forward_hazard_unit #(.CNT_W(4)) dut2 (
        .clk(clk), .reset(rst_a[2]), .id_valid(val_a[2]), .id_src(src_a[2]),
        .id_src_used(used_a[2]), .id_rd(rd_a[2]), .id_regwrite(rw_a[2]),
        .id_memread(mr_a[2]), .flush(fl_a[2]), .id_stall(stall2),
        .ex_fwd_sel(sel2), .stall_cnt(sc2), .fwd_cnt(fc2)
    );

    // One directed cycle: ID inputs, then the outputs expected in that cycle.
    typedef struct {
        int rst, val, s0, s1, u, rd, rw, mr, fl;
        int es, esel, esc, efc;
    } rec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic rec_t mk(int rst, int val, int s0, int s1, int u, int rd,
                                int rw, int mr, int fl, int es, int esel,
                                int esc, int efc);
        rec_t r;
        r.rst = rst; r.val = val; r.s0 = s0; r.s1 = s1; r.u = u; r.rd = rd;
        r.rw = rw; r.mr = mr; r.fl = fl;
        r.es = es; r.esel = esel; r.esc = esc; r.efc = efc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Apply ID inputs to instance k just after the falling edge, then settle.
    task automatic drive(input int k, input int rst, input int val, input int s0,
                         input int s1, input int u, input int rd, input int rw,
                         input int mr, input int fl);
        @(negedge clk);
        rst_a[k]  = 1'(rst);
        val_a[k]  = 1'(val);
        src_a[k]  = {5'(s1), 5'(s0)};
        used_a[k] = 2'(u);
        rd_a[k]   = 5'(rd);
        rw_a[k]   = 1'(rw);
        mr_a[k]   = 1'(mr);
        fl_a[k]   = 1'(fl);
        #1;
    endtask

    task automatic run_table(input int k, input rec_t t[$]);
        foreach (t[i]) begin
            drive(k, t[i].rst, t[i].val, t[i].s0, t[i].s1, t[i].u, t[i].rd,
                  t[i].rw, t[i].mr, t[i].fl);
            chk($sformatf("d%0d v%0d id_stall", k, i), 16'(stall_a[k]), 16'(t[i].es));
            chk($sformatf("d%0d v%0d ex_fwd_sel", k, i), 16'(sel_a[k]), 16'(t[i].esel));
            chk($sformatf("d%0d v%0d stall_cnt", k, i), sc_a[k], 16'(t[i].esc));
            chk($sformatf("d%0d v%0d fwd_cnt", k, i), fc_a[k], 16'(t[i].efc));
            // The load issued at v10 has reached WB by v13.
            if (k == 0 && i == 13) begin
                chk("d0 wb entry", {10'd0, dut0.wb_e_r.valid, dut0.wb_e_r.rd}, {10'd0, 1'b1, 5'd5});
            end
        end
    endtask

    // Reference model: the instructions that entered EX one and two cycles ago.
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } ins_t;

    function automatic logic writes(input ins_t e, input logic [4:0] r);
        return e.v && e.rw && (e.rd != 5'd0) && (e.rd == r);
    endfunction

    task automatic run_random(input int k, input int lb, input int cmax, input int cycles);
        ins_t       age1, age2;
        logic [3:0] m_sel;
        int         m_sc, m_fc;
        logic       held;
        int         rst, val, s0, s1, u, rd, rw, mr, fl;
        age1 = '0; age2 = '0; m_sel = 4'd0; m_sc = 0; m_fc = 0; held = 1'b0;
        val = 0; s0 = 0; s1 = 0; u = 0; rd = 0; rw = 0; mr = 0;
        for (int c = 0; c < cycles; c++) begin
            logic       stall;
            logic       accept;
            logic [3:0] sel;
            if (!held) begin
                val = ($urandom_range(0, 3) != 0) ? 1 : 0;
                s0  = int'($urandom_range(0, 3));
                s1  = int'($urandom_range(0, 3));
                u   = int'($urandom_range(0, 3));
                rd  = int'($urandom_range(0, 3));
                rw  = ($urandom_range(0, 3) != 0) ? 1 : 0;
                mr  = ($urandom_range(0, 2) == 0) ? 1 : 0;
            end
            fl  = ($urandom_range(0, 9) == 0) ? 1 : 0;
            rst = (c == 0 || $urandom_range(0, 59) == 0) ? 1 : 0;
            drive(k, rst, val, s0, s1, u, rd, rw, mr, fl);

            stall = 1'b0;
            sel   = 4'd0;
            for (int i = 0; i < 2; i++) begin
                logic [4:0] s;
                logic       rd_op, h1, h2;
                int         d;
                s     = 5'((i == 0) ? s0 : s1);
                rd_op = u[i] && (s != 5'd0);
                h1    = writes(age1, s);
                h2    = writes(age2, s);
                if (val != 0 && rd_op && ((h1 && age1.mr) || (lb == 2 && h2 && age2.mr)))
                    stall = 1'b1;
                if (!rd_op)                d = 0;
                else if (h1 && !age1.mr)   d = 1;
                else if (h2)               d = (lb == 2 && age2.mr) ? 0 : 2;
                else                       d = 0;
                sel[2*i +: 2] = 2'(d);
            end
            if (fl != 0) stall = 1'b0;

            if (c > 0) begin
                chk($sformatf("d%0d r%0d id_stall", k, c), 16'(stall_a[k]), 16'(stall));
                chk($sformatf("d%0d r%0d ex_fwd_sel", k, c), 16'(sel_a[k]), 16'(m_sel));
                chk($sformatf("d%0d r%0d stall_cnt", k, c), sc_a[k], 16'(m_sc));
                chk($sformatf("d%0d r%0d fwd_cnt", k, c), fc_a[k], 16'(m_fc));
            end

            if (rst != 0) begin
                age1 = '0; age2 = '0; m_sel = 4'd0; m_sc = 0; m_fc = 0;
            end else begin
                if (m_sel != 4'd0 && m_fc < cmax) m_fc++;
                if (stall && m_sc < cmax) m_sc++;
                accept = (val != 0) && !stall && (fl == 0);
                age2   = age1;
                age1   = accept ? ins_t'{1'b1, 5'(rd), 1'(rw), 1'(mr)} : ins_t'('0);
                m_sel  = accept ? sel : 4'd0;
            end
            held = stall && (rst == 0);
        end
    endtask

    initial begin
        rec_t t0[$];
        rec_t t1[$];
        for (int k = 0; k < 3; k++) begin
            rst_a[k] = 1'b1; val_a[k] = 1'b0; src_a[k] = 10'd0; used_a[k] = 2'd0;
            rd_a[k] = 5'd0; rw_a[k] = 1'b0; mr_a[k] = 1'b0; fl_a[k] = 1'b0;
        end
        repeat (2) @(posedge clk);

        //            rst val s0 s1 u  rd rw mr fl | stall sel sc fc
        t0.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0,    0, 0)); // reset
        t0.push_back(mk(0, 1, 1, 2, 3, 3, 1, 0, 0,   0, 0,    0, 0)); // add $3
        t0.push_back(mk(0, 1, 3, 4, 3, 7, 1, 0, 0,   0, 0,    0, 0)); // sub $7,$3,$4
        t0.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1,    0, 0));
        t0.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0,    0, 1));
        t0.push_back(mk(0, 1, 1, 2, 3, 3, 1, 0, 0,   0, 0,    0, 1)); // add $3
        t0.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0,    0, 1)); // nop
        t0.push_back(mk(0, 1, 3, 3, 3, 4, 1, 0, 0,   0, 0,    0, 1)); // or $4,$3,$3
        t0.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 'ha,  0, 1));
        t0.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0,    0, 2));
        t0.push_back(mk(0, 1, 2, 0, 1, 5, 1, 1, 0,   0, 0,    0, 2)); // lw $5
        t0.push_back(mk(0, 1, 5, 1, 3, 6, 1, 0, 0,   1, 0,    0, 2)); // add $6,$5,$1
        t0.push_back(mk(0, 1, 5, 1, 3, 6, 1, 0, 0,   0, 0,    1, 2)); // held
        t0.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 2,    1, 2));
        t0.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0,    1, 3));
        t0.push_back(mk(0, 1, 1, 2, 3, 0, 1, 0, 0,   0, 0,    1, 3)); // add $0
        t0.push_back(mk(0, 1, 0, 0, 3, 7, 1, 0, 0,   0, 0,    1, 3)); // uses $0
        t0.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0,    1, 3));
        t0.push_back(mk(0, 1, 1, 0, 1, 5, 1, 1, 0,   0, 0,    1, 3)); // lw $5
        t0.push_back(mk(0, 1, 5, 1, 3, 6, 1, 0, 1,   0, 0,    1, 3)); // add flushed
        t0.push_back(mk(0, 1, 6, 0, 1, 8, 1, 0, 0,   0, 0,    1, 3)); // reads $6
        t0.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0,    1, 3));
        t0.push_back(mk(0, 1, 1, 0, 1, 5, 1, 1, 0,   0, 0,    1, 3)); // lw $5
        t0.push_back(mk(1, 1, 5, 1, 3, 6, 1, 0, 0,   1, 0,    1, 3)); // reset in stall
        t0.push_back(mk(0, 1, 5, 1, 3, 6, 1, 0, 0,   0, 0,    0, 0));
        t0.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0,    0, 0));

        t1.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0,    0, 0)); // reset
        t1.push_back(mk(0, 1, 1, 0, 1, 5, 1, 1, 0,   0, 0,    0, 0)); // lw $5
        t1.push_back(mk(0, 1, 5, 1, 3, 6, 1, 0, 0,   1, 0,    0, 0)); // add $6,$5,$1
        t1.push_back(mk(0, 1, 5, 1, 3, 6, 1, 0, 0,   1, 0,    1, 0));
        t1.push_back(mk(0, 1, 5, 1, 3, 6, 1, 0, 0,   0, 0,    2, 0));
        t1.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0,    2, 0));
        t1.push_back(mk(0, 1, 1, 0, 1, 5, 1, 1, 0,   0, 0,    2, 0)); // lw $5
        t1.push_back(mk(0, 1, 1, 2, 3, 9, 1, 0, 0,   0, 0,    2, 0)); // or $9
        t1.push_back(mk(0, 1, 5, 1, 3, 6, 1, 0, 0,   1, 0,    2, 0)); // add $6,$5,$1
        t1.push_back(mk(0, 1, 5, 1, 3, 6, 1, 0, 0,   0, 0,    3, 0));
        t1.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0,    3, 0));
        t1.push_back(mk(0, 1, 1, 0, 1, 5, 1, 1, 0,   0, 0,    3, 0)); // lw $5
        t1.push_back(mk(0, 1, 1, 0, 1, 6, 1, 1, 0,   0, 0,    3, 0)); // lw $6
        t1.push_back(mk(0, 1, 5, 6, 3, 7, 1, 0, 0,   1, 0,    3, 0)); // add $7,$5,$6
        t1.push_back(mk(0, 1, 5, 6, 3, 7, 1, 0, 0,   1, 0,    4, 0));
        t1.push_back(mk(0, 1, 5, 6, 3, 7, 1, 0, 0,   0, 0,    5, 0));
        t1.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0,    5, 0));

        run_table(0, t0);
        run_table(1, t1);

        // Saturation: a self-dependent load held in ID stalls every other cycle.
        drive(2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 40; c++) drive(2, 0, 1, 5, 0, 1, 5, 1, 1, 0);
        drive(2, 0, 1, 5, 0, 1, 5, 1, 1, 0);
        chk("d2 stall_cnt saturated", sc_a[2], 16'd15);
        chk("d2 fwd_cnt saturated", fc_a[2], 16'd15);
        drive(2, 0, 1, 5, 0, 1, 5, 1, 1, 0);
        drive(2, 0, 1, 5, 0, 1, 5, 1, 1, 0);
        chk("d2 stall_cnt held", sc_a[2], 16'd15);
        chk("d2 fwd_cnt held", fc_a[2], 16'd15);

        run_random(0, 1, 65535, 400);
        run_random(1, 2, 65535, 400);
        run_random(2, 1, 15, 400);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
